uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Round-robin scheduler that shares one uart_tx transmitter between NUM_REQ byte producers (debug printer, status reporter, command echo, and so on).
- Accepts one byte per valid/ready handshake from the winning requester.
- Launches it with a one-cycle tx_en pulse, waits for tx_done, then enforces an inter-frame idle gap before the next grant.
- A watchdog recovers from a missing tx_done.
- Sits between the requesters and the uart_tx instance at the top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles after a frame before the next grant (0 allowed).
- TIMEOUT_CYCLES, 60000, max clk cycles in WAIT_DONE before abort. Covers a 10-bit frame at 9600 baud with a 50 MHz clock.
- ID_W, localparam = max(1, clog2(NUM_REQ)).
- Counter widths: 16 bits for both counters; legal values are < 65536.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester byte valid; must hold with stable data until ready
- req_data_i  in  NUM_REQ*8  packed bytes; requester k uses bits [8k+7:8k]
- req_ready_o  out  NUM_REQ  one-hot accept, combinational
- tx_en_o  out  1  one-cycle launch pulse to uart_tx
- tx_data_o  out  8  byte to uart_tx
- tx_done_i  in  1  frame-complete pulse from uart_tx
- busy_o  out  1  high in any state other than IDLE
- grant_id_o  out  ID_W  index of the last accepted requester
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (clk edge with rst_i=1), regardless of state:
  - state=IDLE
  - rr pointer=0 (requester 0 has highest priority)
  - tx_en_o=0, tx_data_o=0, grant_id_o=0, timeout_o=0, busy_o=0
  - counters=0
  - An in-flight frame is abandoned; no done is awaited.
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - Winner = first asserted req_valid_i scanning from the pointer upward, with wrap.
  - req_ready_o = one-hot(winner) only in IDLE when any valid is high; 0 otherwise.
  - On the accepting edge: tx_data_o <= winner byte, grant_id_o <= winner, pointer <= (winner+1) mod NUM_REQ, go to LAUNCH.
- LAUNCH:
  - tx_en_o=1 for exactly this one cycle.
  - Next state is WAIT_DONE with the watchdog counter cleared.
- WAIT_DONE:
  - tx_done_i=1 goes to GAP with the gap counter loaded to GAP_CYCLES. If GAP_CYCLES=0, go directly to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: timeout_o pulses for 1 cycle, then the same GAP/IDLE transition as done.
  - If done and timeout coincide on the same cycle, done wins and there is no timeout pulse.
- GAP: the counter decrements; when it is 1, go to IDLE on that edge. This yields exactly GAP_CYCLES cycles in GAP.
- Ignored inputs:
  - tx_done_i outside WAIT_DONE, including the LAUNCH cycle.
  - req_valid_i outside IDLE; no ready is asserted.
- tx_data_o holds its value until the next acceptance.
- Minimum accept-to-accept spacing is 1 (IDLE) + 1 (LAUNCH) + ≥1 (WAIT_DONE) + GAP_CYCLES cycles.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_REQ-1,0,…
- A requester dropping valid before acceptance is allowed; it simply loses its turn.

Decomposition:
- Package uart_ctrl_pkg:
  - state enum {IDLE, LAUNCH, WAIT_DONE, GAP}
  - baud divisor constants (5208/2604/1302/868/434 at 50 MHz)
  - default TIMEOUT value
- One sub-module rr_arbiter:
  - parameter N
  - inputs: req[N], ptr
  - outputs: one-hot gnt[N], gnt_id, any
  - purely combinational; the pointer register lives in uart_tx_arb.

Test Plan:
Bench overrides: GAP_CYCLES=4, TIMEOUT_CYCLES=100, NUM_REQ=4.
1. Single byte: req 2 valid with 0xA5 from reset.
   - Required: ready[2] high in the same cycle.
   - tx_en_o pulses 1 cycle later with tx_data_o=0xA5, grant_id_o=2.
   - tx_done_i injected 20 cycles later; busy_o drops exactly 4 cycles after done.
2. Round-robin: all four valid continuously, each done returned after 10 cycles.
   - Required: grant order 0,1,2,3,0.
   - tx_en_o pulses spaced exactly 1+1+10+4 = 16 cycles apart.
3. Timeout: accept a byte, never assert done.
   - Required: timeout_o pulses once 100 cycles after LAUNCH.
   - After 4 gap cycles the next requester is granted.
4. Done/timeout collision: done asserted on watchdog cycle 99.
   - Required: no timeout_o; normal GAP entry.
5. Spurious done: tx_done_i pulsed in IDLE, in the LAUNCH cycle, and in GAP.
   - Required: no state change; the arbiter still waits for a real done in WAIT_DONE.
6. Reset mid-frame: rst_i asserted 1 cycle during WAIT_DONE, then req 3 valid.
   - Required: outputs return to 0; pointer resets, so req 0 wins if req 0 and req 3 are both valid.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types and constants for the UART transmit-side control blocks.
//   state_t           : arbiter FSM states
//   DATA_W / CNT_W    : byte width and counter width used by the arbiter
//   BAUD_DIV_*        : uart_tx bit-period divisors for a 50 MHz clock
//   DEFAULT_TIMEOUT   : WAIT_DONE watchdog limit, covers one 10-bit frame at
//                       9600 baud (10 * 5208 = 52080 cycles) with margin
//   id_width()        : index width for N requesters, never below 1 bit
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  localparam int BAUD_DIV_9600   = 5208;
  localparam int BAUD_DIV_19200  = 2604;
  localparam int BAUD_DIV_38400  = 1302;
  localparam int BAUD_DIV_57600  = 868;
  localparam int BAUD_DIV_115200 = 434;

  localparam int DEFAULT_TIMEOUT = 60000;
  localparam int DEFAULT_GAP     = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_if
// Bundles the requester handshake and the uart_tx launch/status signals of the
// arbiter. Signal suffixes are from the arbiter's point of view.
//   req_valid_i / req_data_i / req_ready_o : per-requester byte handshake
//   tx_en_o / tx_data_o / tx_done_i        : link to the uart_tx instance
//   busy_o / grant_id_o / timeout_o        : status
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters + uart_tx)
// -----------------------------------------------------------------------------
interface uart_tx_arb_if
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      tx_en_o;
  logic [DATA_W-1:0]         tx_data_o;
  logic                      tx_done_i;
  logic                      busy_o;
  logic [ID_W-1:0]           grant_id_o;
  logic                      timeout_o;

  modport slave (
    input  req_valid_i, req_data_i, tx_done_i,
    output req_ready_o, tx_en_o, tx_data_o, busy_o, grant_id_o, timeout_o
  );

  modport master (
    output req_valid_i, req_data_i, tx_done_i,
    input  req_ready_o, tx_en_o, tx_data_o, busy_o, grant_id_o, timeout_o
  );

endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request found when
// scanning upward from ptr_i, wrapping past N-1 back to 0.
//   req_i    in  N     request vector
//   ptr_i    in  ID_W  highest-priority index (must be < N)
//   gnt_o    out N     one-hot grant, all zero when no request
//   gnt_id_o out ID_W  index of the granted request (0 when none)
//   any_o    out 1     at least one request asserted
// The pointer register is owned by the caller.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  always_comb begin
    logic [ID_W-1:0] idx;
    idx      = '0;
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      // modulo keeps the scan in range for non-power-of-two N
      idx = ID_W'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
// Shares one uart_tx between NUM_REQ byte producers. A round-robin winner is
// accepted in IDLE, launched with a one-cycle tx_en pulse, then the block waits
// for tx_done (guarded by a watchdog) and holds an idle gap before the next
// grant.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus (slave)    : requester handshake, uart_tx link and status outputs
// Parameters:
//   NUM_REQ        : requesters (2..8)
//   GAP_CYCLES     : idle cycles after each frame (0 allowed, < 65536)
//   TIMEOUT_CYCLES : WAIT_DONE cycles before the frame is abandoned (< 65536)
// -----------------------------------------------------------------------------
module uart_tx_arb
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = DEFAULT_GAP,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_tx_arb_if.slave  bus
);

  localparam int ID_W = id_width(NUM_REQ);

  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win_id;
  logic               any_req;
  logic [DATA_W-1:0]  win_byte;
  logic [NUM_REQ-1:0] req_ready;
  logic               timeout;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req_i    (bus.req_valid_i),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (win_id),
    .any_o    (any_req)
  );

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_W'(k)) win_byte = bus.req_data_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    wd_cnt_d   = wd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    req_ready  = '0;
    timeout    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready  = gnt;
          tx_data_d  = win_byte;
          grant_id_d = win_id;
          ptr_d      = next_ptr(win_id);
          state_d    = LAUNCH;
        end
      end

      LAUNCH: begin
        wd_cnt_d = '0;
        state_d  = WAIT_DONE;
      end

      WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
        // done on the final watchdog cycle counts as a normal completion
        if (bus.tx_done_i || (wd_cnt_q == WD_LAST)) begin
          timeout   = ~bus.tx_done_i;
          gap_cnt_d = GAP_LOAD;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q - CNT_W'(1);
        if (gap_cnt_q <= CNT_W'(1)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      wd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      wd_cnt_q   <= wd_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.tx_en_o     = (state_q == LAUNCH);
  assign bus.tx_data_o   = tx_data_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.grant_id_o  = grant_id_q;
  assign bus.timeout_o   = timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arb
// Scoreboard bench for uart_tx_arb with NUM_REQ=4, GAP_CYCLES=4,
// TIMEOUT_CYCLES=100. Bytes are queued per requester; the expected
// (grant id, byte) pair and the tx_done delay for that frame are queued at the
// same time and checked when tx_en pulses.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arb_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arb #(
    .NUM_REQ        (NREQ),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         dq[$];
  logic [7:0] rq[NREQ][$];

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   en_count = 0;
  int   last_en_cyc = 0;
  int   to_count = 0;
  int   to_cyc = 0;
  int   done_cyc = 0;
  int   idle_cyc = 0;
  int   dcnt = 0;
  int   space_exp = 0;
  bit   space_armed = 0;
  bit   armed = 0;
  bit   done_seen = 0;
  bit   spur = 0;
  logic [NREQ-1:0] rdy_s = '0;
  logic [NREQ-1:0] vld_s = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send(input int id, input logic [7:0] data, input int dly);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    sb.push_back(e);
    dq.push_back(dly);
    rq[id].push_back(data);
  endtask

  // One clock: apply handshake + drive inputs after the edge, sample at negedge.
  task automatic tick();
    logic [NREQ-1:0]      v;
    logic [NREQ*8-1:0]    d;
    logic                 resp;
    exp_t                 e;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NREQ; k++)
      if (rdy_s[k] && vld_s[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    v = '0;
    d = '0;
    for (int k = 0; k < NREQ; k++) begin
      v[k] = (rq[k].size() > 0);
      if (v[k]) d[8*k +: 8] = rq[k][0];
    end
    bus.req_valid_i = v;
    bus.req_data_i  = d;
    resp = 1'b0;
    if (armed) begin
      dcnt--;
      if (dcnt == 0) begin
        resp      = 1'b1;
        armed     = 0;
        done_seen = 1;
        done_cyc  = cyc;
      end
    end
    bus.tx_done_i = resp | spur;

    @(negedge clk);
    rdy_s = bus.req_ready_o;
    vld_s = bus.req_valid_i;
    if (bus.tx_en_o) begin
      if (sb.size() == 0) begin
        chk("tx_en_unexpected", {31'd0, bus.tx_en_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tx_data", {24'd0, bus.tx_data_o}, {24'd0, e.data});
        chk("grant_id", {30'd0, bus.grant_id_o}, {30'd0, e.id});
      end
      if (space_exp != 0) begin
        if (space_armed) chk("en_spacing", cyc - last_en_cyc, space_exp);
        space_armed = 1;
      end
      en_count++;
      last_en_cyc = cyc;
      dcnt      = (dq.size() > 0) ? dq.pop_front() : 0;
      armed     = (dcnt != 0);
      done_seen = 0;
    end
    if (bus.timeout_o) begin
      to_count++;
      to_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    foreach (rq[k]) rq[k].delete();
    sb.delete();
    dq.delete();
    armed = 0;
    spur  = 0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
  endtask

  task automatic wait_en(input string tag, input int target);
    int g = 0;
    while (en_count < target && g < 1000) begin tick(); g++; end
    chk(tag, en_count, target);
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done_seen && g < 1000) begin tick(); g++; end
    chk(tag, {31'd0, done_seen}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    tick();
    while ((bus.busy_o || sb.size() != 0) && g < 2000) begin tick(); g++; end
    chk(tag, {31'd0, bus.busy_o}, 32'd0);
    idle_cyc = cyc;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_tx_en"},   {31'd0, bus.tx_en_o},      32'd0);
    chk({pfx, "_tx_data"}, {24'd0, bus.tx_data_o},    32'd0);
    chk({pfx, "_grant"},   {30'd0, bus.grant_id_o},   32'd0);
    chk({pfx, "_timeout"}, {31'd0, bus.timeout_o},    32'd0);
    chk({pfx, "_busy"},    {31'd0, bus.busy_o},       32'd0);
    chk({pfx, "_ready"},   {28'd0, bus.req_ready_o},  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int e0, e1, t0;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.tx_done_i   = 1'b0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset_state("rst");

    // 1: single byte from requester 2
    send(2, 8'hA5, 20);
    tick();
    chk("t1_ready", {28'd0, bus.req_ready_o}, 32'h4);
    tick();
    chk("t1_tx_en", {31'd0, bus.tx_en_o}, 32'd1);
    tick();
    chk("t1_tx_en_once", {31'd0, bus.tx_en_o}, 32'd0);
    chk("t1_data_hold", {24'd0, bus.tx_data_o}, 32'hA5);
    wait_done("t1_done_wait");
    repeat (4) tick();
    chk("t1_busy_gap_end", {31'd0, bus.busy_o}, 32'd1);
    tick();
    chk("t1_busy_drop", {31'd0, bus.busy_o}, 32'd0);

    // 2: round robin from pointer 0, done after 10 cycles each
    do_reset();
    e0 = en_count;
    space_exp   = 16;
    space_armed = 0;
    send(0, 8'h10, 10);
    send(1, 8'h11, 10);
    send(2, 8'h12, 10);
    send(3, 8'h13, 10);
    send(0, 8'h20, 10);
    wait_idle("t2_idle");
    chk("t2_grants", en_count - e0, 5);
    space_exp = 0;

    // 3: watchdog (pointer now 1)
    t0 = to_count;
    send(1, 8'h33, 0);
    send(2, 8'h44, 5);
    wait_en("t3_first_en", en_count + 1);
    e1 = last_en_cyc;
    begin
      int g = 0;
      while (to_count == t0 && g < 300) begin tick(); g++; end
    end
    chk("t3_timeout_seen", to_count - t0, 1);
    chk("t3_timeout_lat", to_cyc - e1, 100);
    wait_en("t3_second_en", en_count + 1);
    chk("t3_regrant", last_en_cyc - to_cyc, 6);
    wait_idle("t3_idle");
    chk("t3_timeout_once", to_count - t0, 1);

    // 4: done on the last watchdog cycle (pointer now 3)
    t0 = to_count;
    send(3, 8'h55, 100);
    send(0, 8'h66, 5);
    wait_en("t4_first_en", en_count + 1);
    e1 = last_en_cyc;
    wait_en("t4_second_en", en_count + 1);
    chk("t4_regrant", last_en_cyc - e1, 106);
    wait_idle("t4_idle");
    chk("t4_no_timeout", to_count - t0, 0);

    // 5: spurious done in IDLE, LAUNCH and GAP (pointer now 1)
    spur = 1;
    tick();
    spur = 0;
    chk("t5_idle_stays", {31'd0, bus.busy_o}, 32'd0);
    e0 = en_count;
    send(1, 8'h77, 30);
    tick();
    spur = 1;
    tick();
    spur = 0;
    chk("t5_launch", en_count - e0, 1);
    tick();
    chk("t5_wait_busy", {31'd0, bus.busy_o}, 32'd1);
    wait_done("t5_done_wait");
    tick();
    spur = 1;
    tick();
    spur = 0;
    wait_idle("t5_idle");
    chk("t5_frame_len", idle_cyc - last_en_cyc, 35);

    // 6: reset during WAIT_DONE (pointer now 2)
    send(2, 8'h88, 0);
    wait_en("t6_en", en_count + 1);
    repeat (5) tick();
    chk("t6_in_frame", {31'd0, bus.busy_o}, 32'd1);
    do_reset();
    chk_reset_state("t6_rst");
    send(0, 8'h99, 5);
    send(3, 8'hAA, 5);
    tick();
    chk("t6_ready_ptr0", {28'd0, bus.req_ready_o}, 32'h1);
    wait_idle("t6_idle");
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
